// File: rtl/key_schedule_iter.sv
// rtl/key_schedule_iter.sv - iterative AES-128 round key generator with valid/ready output

// sbox4 - applies the AES S-box to each byte of a 32-bit word
module sbox4 (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine map
    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Bytewise substitution of the whole word
    always_comb begin
        dout = {sub_byte(din[31:24]), sub_byte(din[23:16]),
                sub_byte(din[15:8]),  sub_byte(din[7:0])};
    end

endmodule

// key_schedule_iter - produces round keys 0..NR one per accepted handshake
module key_schedule_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t       state;
    state_t       state_next;
    logic [7:0]   rcon;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t_word;
    logic [31:0]  w0_n;
    logic [31:0]  w1_n;
    logic [31:0]  w2_n;
    logic [31:0]  w3_n;
    logic         accept;
    logic         advance;
    logic         finish;

    // Handshake qualifiers; rk_valid is exactly "in RUN"
    assign accept  = (state == IDLE) && start;
    assign advance = (state == RUN) && rk_ready && (round_idx != LAST_ROUND);
    assign finish  = (state == RUN) && rk_ready && (round_idx == LAST_ROUND);

    // Next-key datapath, purely from the current round_key register
    assign rot_w3 = {round_key[23:0], round_key[31:24]};

    sbox4 u_sbox4 (
        .din  (rot_w3),
        .dout (sub_w3)
    );

    assign t_word = sub_w3 ^ {rcon, 24'h000000};
    assign w0_n   = round_key[127:96] ^ t_word;
    assign w1_n   = round_key[95:64]  ^ w0_n;
    assign w2_n   = round_key[63:32]  ^ w1_n;
    assign w3_n   = round_key[31:0]   ^ w2_n;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: start only matters in IDLE, final handshake returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state register only
    always_comb begin
        rk_valid = (state == RUN);
        busy     = (state == RUN);
    end

    // Round key, round index, rcon and done pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_key <= 128'h0;
            round_idx <= 4'd0;
            rcon      <= 8'h01;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                round_key <= key_in;
                round_idx <= 4'd0;
                rcon      <= 8'h01;
            end else if (advance) begin
                round_key <= {w0_n, w1_n, w2_n, w3_n};
                round_idx <= round_idx + 4'd1;
                rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_iter.sv
// tb/tb_key_schedule_iter.sv - scoreboard bench for key_schedule_iter with reference key expansion
module tb_key_schedule_iter;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    key_schedule_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t     exp_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    logic [7:0] sbox_t [256];
    logic [7:0] rcon_t [11];
    bit       m_busy = 0;
    bit       m_done = 0;
    int       m_idx  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from exp/log tables over generator 3, then the bitwise affine map
    function automatic void build_tables();
        logic [7:0] ex [255];
        int         lg [256];
        logic [7:0] inv;
        logic [7:0] s;
        ex[0] = 8'h01;
        for (int i = 1; i < 255; i++) ex[i] = ex[i-1] ^ xt(ex[i-1]);
        for (int i = 0; i < 255; i++) lg[ex[i]] = i;
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox_t[a] = s ^ 8'h63;
        end
        rcon_t[0] = 8'h00;
        rcon_t[1] = 8'h01;
        for (int j = 2; j < 11; j++) rcon_t[j] = xt(rcon_t[j-1]);
    endfunction

    // Textbook word-array expansion; pushes all eleven expected round keys
    function automatic void push_schedule(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        exp_t        e;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rcon_t[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) begin
            e.idx = 4'(r);
            e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            exp_q.push_back(e);
        end
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Protocol model: accepts start in idle, advances on ready, queues expected keys
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0;
            m_done = 0;
            m_idx  = 0;
            exp_q.delete();
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1;
                    m_idx  = 0;
                    push_schedule(key_in);
                end
            end else if (rk_ready) begin
                if (m_idx == 10) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    // Monitor: control outputs every cycle, key/index on each handshake, stability under stall
    initial begin : monitor
        bit           hold_v;
        logic [131:0] held;
        exp_t         e;
        hold_v = 0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 0;
            end else begin
                check("ctrl{valid,busy,done}", {125'h0, rk_valid, busy, done},
                      {125'h0, m_busy, m_busy, m_done});
                if (hold_v)
                    check("stall stable", {round_idx, round_key}, held);
                if (rk_valid && rk_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected handshake idx", {124'h0, round_idx}, 128'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("handshake idx", {124'h0, round_idx}, {124'h0, e.idx});
                        check("handshake key", round_key, e.key);
                    end
                end
                hold_v = rk_valid && !rk_ready;
                held   = {round_idx, round_key};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [3:0] r, output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (rk_valid && round_idx == r) ok = 1;
        end
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        if (!ok) timeout(name);
    endtask

    task automatic pulse_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
    endtask

    initial begin : stim
        bit ok;
        build_tables();
        rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        repeat (2) @(negedge clk);
        check("reset ctrl", {125'h0, rk_valid, busy, done}, 128'h0);
        check("reset key", round_key, 128'h0);
        check("reset idx", {124'h0, round_idx}, 128'h0);
        tick();
        rst = 1'b0;
        tick();

        // FIPS vector, ready held high: one key per cycle, done on the 12th
        rk_ready = 1'b1;
        pulse_start(FIPS_KEY);
        for (int r = 0; r <= 10; r++) begin
            @(negedge clk);
            check("fips seq idx", {124'h0, round_idx}, 128'(r));
            if (r == 0)  check("fips r0", round_key, FIPS_KEY);
            if (r == 1)  check("fips r1", round_key, FIPS_R1);
            if (r == 2)  check("fips r2", round_key, FIPS_R2);
            if (r == 10) check("fips r10", round_key, FIPS_R10);
        end
        @(negedge clk);
        check("fips done", {127'h0, done}, 128'h1);
        tick();

        // Zero key
        pulse_start(128'h0);
        wait_idx(4'd1, ok);
        if (!ok) timeout("zero r1"); else check("zero r1", round_key, ZERO_R1);
        wait_idx(4'd10, ok);
        if (!ok) timeout("zero r10"); else check("zero r10", round_key, ZERO_R10);
        wait_done("zero done");
        tick();

        // Backpressure at round 3 for five cycles
        pulse_start(FIPS_KEY);
        repeat (3) tick();
        rk_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp idx", {124'h0, round_idx}, 128'd3);
            check("bp key", round_key, FIPS_R3);
        end
        tick();
        rk_ready = 1'b1;
        wait_idx(4'd10, ok);
        if (!ok) timeout("bp r10"); else check("bp r10", round_key, FIPS_R10);
        wait_done("bp done");
        tick();

        // start during RUN at round 5 is ignored
        pulse_start(FIPS_KEY);
        repeat (5) tick();
        pulse_start({4{32'hdeadbeef}});
        wait_idx(4'd10, ok);
        if (!ok) timeout("ign r10"); else check("ign r10", round_key, FIPS_R10);
        wait_done("ign done");
        tick();

        // Asynchronous reset in the middle of round 7
        pulse_start(FIPS_KEY);
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async rst ctrl", {125'h0, rk_valid, busy, done}, 128'h0);
        check("async rst key", {124'h0, round_idx} | round_key, 128'h0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start(FIPS_KEY);
        wait_idx(4'd10, ok);
        if (!ok) timeout("post rst r10"); else check("post rst r10", round_key, FIPS_R10);

        // Back-to-back: zero-key start in the done cycle
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = 128'h0;
        @(negedge clk);
        check("b2b done", {127'h0, done}, 128'h1);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("b2b r0", {rk_valid, round_idx, round_key}, {1'b1, 4'd0, 128'h0});
        @(negedge clk);
        check("b2b r1", round_key, ZERO_R1);
        wait_done("b2b done2");
        tick();

        // Randomized traffic: random keys, random ready, random start pulses
        for (int c = 0; c < 1500; c++) begin
            rk_ready = ($urandom_range(0, 3) != 0);
            start    = ($urandom_range(0, 11) == 0);
            key_in   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !done) ok = 1;
        end
        if (!ok) timeout("drain");
        repeat (2) @(negedge clk);
        check("queue empty", 128'(exp_q.size()), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
